// File: rtl/period_detector_pkg.sv
// Shared fixed-point constants and zero-crossing state encoding for the
// period detector and the oscillator blocks.
package period_detector_pkg;

    localparam int                 FRAC_BITS = 20;
    localparam logic signed [31:0] FP_ONE    = 32'sd1 <<< FRAC_BITS;

    typedef enum logic [0:0] {
        SEEK_LOW  = 1'b0,
        SEEK_HIGH = 1'b1
    } zc_state_e;

    // Larger minus smaller, so the result never wraps for in-range periods.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/period_detector_if.sv
// Sample stream in, period measurement out.
interface period_detector_if;

    logic signed [31:0] sample_in;
    logic               sample_valid;
    logic        [31:0] wave_length;
    logic               length_valid;
    logic               locked;
    logic               timeout;

    modport master (
        output sample_in, sample_valid,
        input  wave_length, length_valid, locked, timeout
    );

    modport slave (
        input  sample_in, sample_valid,
        output wave_length, length_valid, locked, timeout
    );

endinterface

// File: rtl/zero_cross_detector.sv
// Hysteresis FSM: arms below -HYST, strobes a rising crossing at >= HYST.
module zero_cross_detector
    import period_detector_pkg::*;
#(
    parameter logic signed [31:0] HYST = 32'sd65536
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [31:0] sample_in,
    input  logic               sample_valid,
    input  logic               force_low,
    output logic               crossing
);

    zc_state_e          state_q, state_d;
    logic signed [31:0] neg_hyst;

    assign neg_hyst = -HYST;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        crossing = 1'b0;
        if (sample_valid) begin
            case (state_q)
                SEEK_LOW: begin
                    if (sample_in <= neg_hyst) state_d = SEEK_HIGH;
                end
                SEEK_HIGH: begin
                    if (sample_in >= HYST) begin
                        state_d  = SEEK_LOW;
                        crossing = 1'b1;
                    end
                end
                default: state_d = SEEK_LOW;
            endcase
        end
        // A timeout re-arms the detector from scratch.
        if (force_low) state_d = SEEK_LOW;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) state_q <= SEEK_LOW;
        else       state_q <= state_d;
    end

endmodule

// File: rtl/period_detector.sv
// Measures the sample count between rising crossings, reports period-1,
// flags lock between consecutive periods and times out on silence.
module period_detector
    import period_detector_pkg::*;
#(
    parameter logic signed [31:0] HYST       = 32'sd65536,
    parameter logic        [31:0] MAX_LENGTH = 32'd1048576,
    parameter logic        [31:0] TOLERANCE  = 32'd1
) (
    input  logic               clk,
    input  logic               reset,
    period_detector_if.slave   bus
);

    logic        crossing;
    logic        timeout_evt;

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] prev_p_q, prev_p_d;
    logic [31:0] wave_length_q, wave_length_d;
    logic        have_first_q, have_first_d;
    logic        have_prev_q, have_prev_d;
    logic        length_valid_q, length_valid_d;
    logic        locked_q, locked_d;
    logic        timeout_q, timeout_d;

    assign timeout_evt = bus.sample_valid && have_first_q && (cnt_q == MAX_LENGTH - 32'd1);

    zero_cross_detector #(.HYST(HYST)) u_zcd (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (bus.sample_in),
        .sample_valid (bus.sample_valid),
        .force_low    (timeout_evt),
        .crossing     (crossing)
    );

    always_comb begin
        cnt_d          = cnt_q;
        prev_p_d       = prev_p_q;
        wave_length_d  = wave_length_q;
        have_first_d   = have_first_q;
        have_prev_d    = have_prev_q;
        locked_d       = locked_q;
        length_valid_d = 1'b0;
        timeout_d      = 1'b0;

        // Timeout takes priority over a crossing on the same sample.
        if (timeout_evt) begin
            cnt_d        = '0;
            have_first_d = 1'b0;
            have_prev_d  = 1'b0;
            locked_d     = 1'b0;
            timeout_d    = 1'b1;
        end else if (crossing) begin
            cnt_d        = 32'd1;
            have_first_d = 1'b1;
            if (have_first_q) begin
                wave_length_d  = cnt_q - 32'd1;
                length_valid_d = 1'b1;
                prev_p_d       = cnt_q;
                have_prev_d    = 1'b1;
                locked_d       = have_prev_q && (abs_diff(cnt_q, prev_p_q) <= TOLERANCE);
            end
        end else if (bus.sample_valid && have_first_q) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= '0;
            prev_p_q       <= '0;
            wave_length_q  <= '0;
            have_first_q   <= 1'b0;
            have_prev_q    <= 1'b0;
            length_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            prev_p_q       <= prev_p_d;
            wave_length_q  <= wave_length_d;
            have_first_q   <= have_first_d;
            have_prev_q    <= have_prev_d;
            length_valid_q <= length_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.wave_length  = wave_length_q;
    assign bus.length_valid = length_valid_q;
    assign bus.locked       = locked_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: doc/period_detector.md
PERIOD_DETECTOR -- requirements
Module: period_detector

Interface
REQ-001 Parameter HYST, default 32'sd65536 (0.0625 in Q11.20), meaning the hysteresis threshold magnitude for crossing detection.
REQ-002 Parameter MAX_LENGTH, default 32'd1048576, meaning the sample-tick count at which the measurement is abandoned (timeout).
REQ-003 Parameter TOLERANCE, default 32'd1, meaning the maximum period difference between consecutive measurements that still counts as stable.
REQ-004 Port clk, input, 1, meaning the single clock; all logic is on posedge clk.
REQ-005 Port reset, input, 1, meaning a synchronous, active-high reset.
REQ-006 Port sample_in, input, 32, meaning a signed Q11.20 audio sample where full scale ±1.0 is ±(1<<20).
REQ-007 Port sample_valid, input, 1, meaning sample_in is accepted on this cycle.
REQ-008 Port wave_length, output, 32, meaning the measured period minus 1, in the same convention as the oscillator wave_length parameter.
REQ-009 Port length_valid, output, 1, meaning a one-cycle pulse when wave_length updates.
REQ-010 Port locked, output, 1, meaning the two most recent periods agree within TOLERANCE.
REQ-011 Port timeout, output, 1, meaning a one-cycle pulse when the count reaches MAX_LENGTH.

Function
REQ-012 Two-state FSM SHALL run: SEEK_LOW and SEEK_HIGH; state advances only on cycles with sample_valid=1.
REQ-013 SEEK_LOW -> SEEK_HIGH SHALL occur when signed sample_in <= -HYST.
REQ-014 SEEK_HIGH -> SEEK_LOW SHALL occur when signed sample_in >= HYST; this sample is a rising crossing.
REQ-015 Flag have_first SHALL clear on reset and timeout; the first rising crossing SHALL set have_first, set cnt=1, and produce no output.
REQ-016 With have_first=1, each valid non-crossing sample SHALL do cnt<=cnt+1; each rising crossing SHALL latch P=cnt, then set cnt<=1.
REQ-017 On a latched P, the cycle after the crossing sample SHALL drive wave_length=P-1 with length_valid=1; latency is exactly 1 clk.
REQ-018 wave_length SHALL hold its value between updates.
REQ-019 When cnt would reach MAX_LENGTH: cnt<=0, have_first<=0, state<=SEEK_LOW, locked<=0, timeout pulses 1 cycle (next clk); wave_length is unchanged.
REQ-020 On each new P with a previous P present, locked SHALL be set when |P-prev_P| <= TOLERANCE and cleared otherwise; the first P after have_first sets leaves locked=0.
REQ-021 Comparison SHALL use unsigned 32-bit subtraction of the larger minus the smaller; no overflow is possible since P < MAX_LENGTH.
REQ-022 A crossing coinciding with the timeout count SHALL resolve as timeout (timeout wins).
REQ-023 sample_valid=0 cycles SHALL change no state and no counter.

Reset
REQ-024 reset SHALL set state=SEEK_LOW, cnt=0, have_first=0, prev_P=0, wave_length=0, length_valid=0, locked=0, timeout=0 on the next clk edge.
REQ-025 reset asserted mid-measurement SHALL discard the partial count; no length_valid follows.

Structure
REQ-026 A shared package SHALL hold FRAC_BITS=20, FP_ONE=1<<20, and the state enum {SEEK_LOW, SEEK_HIGH}; the oscillator blocks reuse these.
REQ-027 One sub-module, zero_cross_detector, SHALL contain the FSM and hysteresis compare and emit a crossing strobe; period_detector SHALL hold the counters, lock logic and outputs.

Verification
REQ-028 Drive the oscillator saw (wave_length=99), sample_valid=1 continuously -> from the second crossing onward, wave_length=99 and length_valid pulses every 100 cycles; locked=1 after the second reported P.
REQ-029 Constant sample_in=0 for 1048576 valid cycles after one crossing (MAX_LENGTH default) -> timeout pulses once, locked=0, wave_length unchanged.
REQ-030 Square wave ±0.5 with period 40, sample_valid high every other cycle -> wave_length=19.
REQ-031 Saw with ±0.03 noise under HYST=0.0625 -> no extra crossings; wave_length stays 99.
REQ-032 Saw wave_length switched from 99 to 149 -> the next P=150 reports wave_length=149 with locked=0, then locked=1 after the following period.
REQ-033 Assert reset 50 cycles into a period -> all outputs 0 next cycle; the first length_valid arrives only after two new crossings.
